// File: rtl/hazard_pkg.sv
// Shared types for the RAW-hazard scoreboard: the in-flight entry layout and
// the forwarding-source encodings driven into EX.
package hazard_pkg;

  // Entries carry a fixed-width rd so the struct is parameter-independent;
  // register addresses are zero-extended into it.
  localparam int RD_MAX_W = 8;

  localparam int FWD_REGFILE = 0;
  localparam int FWD_MEM     = 1;
  localparam int FWD_WB      = 2;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic                is_load;
    logic [RD_MAX_W-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard: decode requests in, stall,
// forwarding selects and stall counter out.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3,
  parameter int CNT_W      = 16
);

  localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_we;
  logic                  id_is_load;
  logic                  flush;
  logic                  nop;
  logic [SEL_W-1:0]      fwd_sel_a;
  logic [SEL_W-1:0]      fwd_sel_b;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output id_rd, id_we, id_is_load, flush,
    input  nop, fwd_sel_a, fwd_sel_b, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  id_rd, id_we, id_is_load, flush,
    output nop, fwd_sel_a, fwd_sel_b, stall_cycles
  );

endinterface

// File: rtl/hazard_match.sv
// Per-source RAW search over the in-flight entries; the youngest producer
// decides. Behaviour depends on `FORWARD_EN` (forwarding vs. stall-only).
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = 2
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  use_src,
  input  logic                  id_valid,
  output logic                  hit,
  output logic                  stall,
  output logic [SEL_W-1:0]      sel
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DEPTH - 1);

  logic [DEPTH-1:0]    match_s;
  logic [SEL_W-1:0]    idx_s;
  logic                near_s;
  logic [RD_MAX_W-1:0] src_ext_s;

  assign src_ext_s = RD_MAX_W'(src);

  // Match every entry, scanning oldest to youngest so the lowest hit wins.
  always_comb begin
    match_s = {DEPTH{1'b0}};
    idx_s   = {SEL_W{1'b0}};
    for (int k = DEPTH - 1; k >= 0; k--) begin
      match_s[k] = entries[k].valid & entries[k].we & (entries[k].rd == src_ext_s)
                   & use_src & id_valid;
      idx_s      = match_s[k] ? SEL_W'(k) : idx_s;
    end
  end

  // A producer in the last stage writes the regfile write-first: no action.
  assign hit    = |match_s;
  assign near_s = hit & (idx_s < LAST_IDX);

`ifdef FORWARD_EN
  localparam logic [SEL_W-1:0] LOAD_IDX = SEL_W'(LOAD_READY - 1);

  assign stall = near_s & entries[idx_s].is_load & (idx_s < LOAD_IDX);
  assign sel   = near_s ? (idx_s + SEL_W'(1'b1)) : SEL_W'(FWD_REGFILE);
`else
  localparam int unused_load_ready = LOAD_READY;

  logic [DEPTH-1:0] unused_load_s;

  // Load flags play no role without forwarding.
  always_comb begin
    unused_load_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      unused_load_s[k] = entries[k].is_load;
    end
  end

  assign stall = near_s;
  assign sel   = SEL_W'(FWD_REGFILE);
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW-hazard scoreboard for decode: nop stall, registered EX forwarding
// selects, saturating stall counter. Define FORWARD_EN to enable forwarding.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  bus
);

  localparam int SEL_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = $bits(sb_entry_t);

  sb_entry_t [DEPTH-1:0] entries_r;
  sb_entry_t             new_entry_s;
  logic                  hit_a_s;
  logic                  hit_b_s;
  logic                  stall_a_s;
  logic                  stall_b_s;
  logic [SEL_W-1:0]      sel_a_s;
  logic [SEL_W-1:0]      sel_b_s;
  logic                  nop_s;
  logic                  accept_s;
  logic [CNT_W-1:0]      stall_cnt_r;
  logic                  unused_hit_s;

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) u_match_a (
    .entries  (entries_r),
    .src      (bus.id_rs1),
    .use_src  (bus.id_use_rs1),
    .id_valid (bus.id_valid),
    .hit      (hit_a_s),
    .stall    (stall_a_s),
    .sel      (sel_a_s)
  );

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) u_match_b (
    .entries  (entries_r),
    .src      (bus.id_rs2),
    .use_src  (bus.id_use_rs2),
    .id_valid (bus.id_valid),
    .hit      (hit_b_s),
    .stall    (stall_b_s),
    .sel      (sel_b_s)
  );

  assign unused_hit_s = hit_a_s ^ hit_b_s;

  // Stall decision (flush wins) and the entry that enters EX this cycle.
  always_comb begin
    nop_s               = (stall_a_s | stall_b_s) & ~bus.flush;
    accept_s            = bus.id_valid & ~nop_s & ~bus.flush;
    new_entry_s         = {ENTRY_W{1'b0}};
    new_entry_s.valid   = accept_s;
    new_entry_s.we      = accept_s & bus.id_we;
`ifdef FORWARD_EN
    new_entry_s.is_load = accept_s & bus.id_is_load;
`else
    new_entry_s.is_load = 1'b0;
`endif
    new_entry_s.rd      = accept_s ? RD_MAX_W'(bus.id_rd) : {RD_MAX_W{1'b0}};
  end

  // Advance in-flight destinations one stage per cycle; WB entry drops off.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries_r <= {(ENTRY_W * DEPTH){1'b0}};
    end else begin
      entries_r <= {entries_r[DEPTH-2:0], new_entry_s};
    end
  end

  // Saturating count of cycles spent with decode held.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (nop_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

`ifdef FORWARD_EN
  logic [SEL_W-1:0] fwd_sel_a_r;
  logic [SEL_W-1:0] fwd_sel_b_r;

  // Selects travel with the instruction into EX; bubbles read the regfile.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_sel_a_r <= SEL_W'(FWD_REGFILE);
      fwd_sel_b_r <= SEL_W'(FWD_REGFILE);
    end else if (accept_s) begin
      fwd_sel_a_r <= sel_a_s;
      fwd_sel_b_r <= sel_b_s;
    end else begin
      fwd_sel_a_r <= SEL_W'(FWD_REGFILE);
      fwd_sel_b_r <= SEL_W'(FWD_REGFILE);
    end
  end

  assign bus.fwd_sel_a = fwd_sel_a_r;
  assign bus.fwd_sel_b = fwd_sel_b_r;
`else
  logic [2*SEL_W:0] unused_fwd_s;

  assign unused_fwd_s  = {sel_a_s, sel_b_s, bus.id_is_load};
  assign bus.fwd_sel_a = SEL_W'(FWD_REGFILE);
  assign bus.fwd_sel_b = SEL_W'(FWD_REGFILE);
`endif

  assign bus.nop          = nop_s;
  assign bus.stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed decode sequences push the
// expected per-cycle outputs; a negedge monitor pops and compares.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    int row;
    int nop;
    int sel_a;
    int sel_b;
    int cnt;
    int small_cnt;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks;
  int   errors;
  int   exp_cnt;
  int   row_no;

  hazard_scoreboard_if #(.REG_ADDR_W(4), .DEPTH(3), .CNT_W(16)) bus ();
  hazard_scoreboard_if #(.REG_ADDR_W(4), .DEPTH(3), .CNT_W(2))  bus_s ();

  hazard_scoreboard #(.REG_ADDR_W(4), .DEPTH(3), .LOAD_READY(2), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Narrow-counter copy sees identical stimulus to exercise saturation.
  hazard_scoreboard #(.REG_ADDR_W(4), .DEPTH(3), .LOAD_READY(2), .CNT_W(2)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  assign bus_s.id_valid   = bus.id_valid;
  assign bus_s.id_rs1     = bus.id_rs1;
  assign bus_s.id_rs2     = bus.id_rs2;
  assign bus_s.id_use_rs1 = bus.id_use_rs1;
  assign bus_s.id_use_rs2 = bus.id_use_rs2;
  assign bus_s.id_rd      = bus.id_rd;
  assign bus_s.id_we      = bus.id_we;
  assign bus_s.id_is_load = bus.id_is_load;
  assign bus_s.flush      = bus.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int row, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endfunction

  // One decode cycle: drive inputs, queue the outputs expected this cycle.
  task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit we, input bit ld, input bit fl, input bit rst,
                      input bit e_nop, input int e_a, input int e_b);
    exp_t e;
    @(posedge clk);
    #1;
    bus.id_valid   = v;
    bus.id_rs1     = 4'(rs1);
    bus.id_use_rs1 = u1;
    bus.id_rs2     = 4'(rs2);
    bus.id_use_rs2 = u2;
    bus.id_rd      = 4'(rd);
    bus.id_we      = we;
    bus.id_is_load = ld;
    bus.flush      = fl;
    reset          = rst;
    e.row       = row_no;
    e.nop       = int'(e_nop);
    e.sel_a     = e_a;
    e.sel_b     = e_b;
    e.cnt       = exp_cnt;
    e.small_cnt = (exp_cnt > 3) ? 3 : exp_cnt;
    exp_q.push_back(e);
    row_no++;
    if (rst) exp_cnt = 0;
    else if (e_nop && exp_cnt < 65535) exp_cnt++;
  endtask

  task automatic idle(input int e_a, input int e_b);
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_a, e_b);
  endtask

  // Load r5 followed by ADD r6,r5,r5 held in decode until it issues.
  task automatic load_use();
    step(1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
`ifndef FORWARD_EN
    step(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
`endif
    step(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(FWD ? FWD_WB : FWD_REGFILE, FWD ? FWD_WB : FWD_REGFILE);
    idle(0, 0);
    idle(0, 0);
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("nop",          mon_e.row, int'(bus.nop),          mon_e.nop);
      check("fwd_sel_a",    mon_e.row, int'(bus.fwd_sel_a),    mon_e.sel_a);
      check("fwd_sel_b",    mon_e.row, int'(bus.fwd_sel_b),    mon_e.sel_b);
      check("stall_cycles", mon_e.row, int'(bus.stall_cycles), mon_e.cnt);
      check("small_nop",    mon_e.row, int'(bus_s.nop),        mon_e.nop);
      check("small_count",  mon_e.row, int'(bus_s.stall_cycles), mon_e.small_cnt);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; exp_cnt = 0; row_no = 0;
    reset = 1'b1;
    bus.id_valid = 1'b0; bus.id_rs1 = 4'd0; bus.id_rs2 = 4'd0;
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0; bus.id_rd = 4'd0;
    bus.id_we = 1'b0; bus.id_is_load = 1'b0; bus.flush = 1'b0;
    @(posedge clk);
    // Reset state
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

    // ADD r3,r1,r2 then SUB r4,r3,r1
    step(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 3, 1'b1, 1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, !FWD, 0, 0);
`ifndef FORWARD_EN
    step(1'b1, 3, 1'b1, 1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    step(1'b1, 3, 1'b1, 1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
`endif
    idle(FWD ? FWD_MEM : FWD_REGFILE, FWD_REGFILE);
    idle(0, 0);
    idle(0, 0);

    // ADD r3, independent XOR r7, then r3 read as rs2
    step(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 8, 1'b1, 9, 1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1, 1'b1, 3, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0, !FWD, 0, 0);
`ifndef FORWARD_EN
    step(1'b1, 1, 1'b1, 3, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
`endif
    idle(FWD_REGFILE, FWD ? FWD_WB : FWD_REGFILE);
    idle(0, 0);
    idle(0, 0);

    // Load-use
    load_use();

    // Producer in WB needs nothing; rd match with we=0 is ignored
    step(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1, 1'b1, 2, 1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1, 1'b1, 2, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 3, 1'b1, 3, 1'b1, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(0, 0);
    step(1'b1, 1, 1'b1, 2, 1'b1, 11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 11, 1'b1, 0, 1'b0, 13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    idle(0, 0);

    // Flush in the stall cycle: no nop, consumer of r6 sees no producer
    step(1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 6, 1'b1, 0, 1'b0, 13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    idle(0, 0);

    // Reset asserted during the stall cycle
    step(1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    step(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    idle(0, 0);

    // Repeated load-use stalls drive the 2-bit counter into saturation
    for (int i = 0; i < 4; i++) begin
      load_use();
    end

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
